// File: rtl/ifu_pc.sv
// Instruction-fetch PC stage: holds the architectural PC, selects the next PC and
// traps any fetch target outside instruction memory into a sticky HALT state.
module ifu_pc #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic [1:0]  NPCOp,
    input  logic        Zero,
    input  logic [15:0] Imm16,
    input  logic [25:0] Index26,
    input  logic [31:0] RegTarget,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic [9:0]  ImAddr,
    output logic        Halted,
    output logic        AddrErr
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    // 33-bit limit so a memory reaching the top of the address space cannot overflow.
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] npc;
    logic [31:0] br_offset;
    logic        npc_legal;

    assign PC4       = pc_q + 32'd4;
    assign br_offset = {{14{Imm16[15]}}, Imm16, 2'b00};

    always_comb begin
        npc = PC4;
        unique case (npc_op_e'(NPCOp))
            NPC_SEQ:    npc = PC4;
            NPC_BRANCH: npc = Zero ? (PC4 + br_offset) : PC4;
            NPC_JUMP:   npc = {PC4[31:28], Index26, 2'b00};
            NPC_JR:     npc = RegTarget;
            default:    npc = PC4;
        endcase
    end

    assign npc_legal = (npc[1:0] == 2'b00) && (npc >= IM_BASE) && ({1'b0, npc} < IM_LIMIT);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_err_d = addr_err_q;
        unique case (state_q)
            RUN: begin
                // A stalled cycle never evaluates legality, even for a bad target.
                if (!Stall) begin
                    if (!npc_legal) begin
                        addr_err_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_d = npc;
                    end
                end
            end
            HALT: ;
            default: state_d = HALT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= RUN;
            pc_q       <= PC_RESET;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
        end
    end

    // The PC is always word aligned, so the word offset needs no borrow from bits [1:0].
    assign ImAddr  = pc_q[11:2] - IM_BASE[11:2];
    assign PC      = pc_q;
    assign Halted  = (state_q == HALT);
    assign AddrErr = addr_err_q;

endmodule

// File: tb/tb_ifu_pc.sv
// Directed bench for ifu_pc: sequential, branch, jump, jump-register, stall,
// out-of-range trapping and reset recovery, with hand-computed expectations.
module tb_ifu_pc;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic [1:0]  NPCOp;
    logic        Zero;
    logic [15:0] Imm16;
    logic [25:0] Index26;
    logic [31:0] RegTarget;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic [9:0]  ImAddr;
    logic        Halted;
    logic        AddrErr;

    int checks   = 0;
    int failures = 0;

    ifu_pc dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Stall     (Stall),
        .NPCOp     (NPCOp),
        .Zero      (Zero),
        .Imm16     (Imm16),
        .Index26   (Index26),
        .RegTarget (RegTarget),
        .PC        (PC),
        .PC4       (PC4),
        .ImAddr    (ImAddr),
        .Halted    (Halted),
        .AddrErr   (AddrErr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [31:0] exp_pc, input logic [9:0] exp_ia,
                            input logic exp_halt, input logic exp_err);
        check({tag, ".pc"},      PC,             exp_pc);
        check({tag, ".pc4"},     PC4,            exp_pc + 32'd4);
        check({tag, ".imaddr"},  {22'd0, ImAddr}, {22'd0, exp_ia});
        check({tag, ".halted"},  {31'd0, Halted}, {31'd0, exp_halt});
        check({tag, ".addrerr"}, {31'd0, AddrErr}, {31'd0, exp_err});
    endtask

    task automatic drive(input logic stall, input logic [1:0] op, input logic zero,
                         input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] tgt);
        Stall     = stall;
        NPCOp     = op;
        Zero      = zero;
        Imm16     = imm;
        Index26   = idx;
        RegTarget = tgt;
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        step();
        check_pc("reset", 32'h3000, 10'h000, 1'b0, 1'b0);
        Reset = 1'b0;

        // Sequential fetch
        step(); check_pc("seq1", 32'h3004, 10'h001, 1'b0, 1'b0);
        step(); check_pc("seq2", 32'h3008, 10'h002, 1'b0, 1'b0);
        step(); check_pc("seq3", 32'h300C, 10'h003, 1'b0, 1'b0);

        // Branch taken / not taken from 0x3008
        drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h3008);
        step(); check_pc("jr_3008a", 32'h3008, 10'h002, 1'b0, 1'b0);
        drive(1'b0, 2'b01, 1'b1, 16'hFFFE, 26'h0, 32'h0);
        step(); check_pc("br_taken", 32'h3004, 10'h001, 1'b0, 1'b0);
        drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h3008);
        step(); check_pc("jr_3008b", 32'h3008, 10'h002, 1'b0, 1'b0);
        drive(1'b0, 2'b01, 1'b0, 16'hFFFE, 26'h0, 32'h0);
        step(); check_pc("br_not_taken", 32'h300C, 10'h003, 1'b0, 1'b0);

        // Jump and jump-register
        drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h3000);
        step(); check_pc("jr_base", 32'h3000, 10'h000, 1'b0, 1'b0);
        drive(1'b0, 2'b10, 1'b0, 16'h0, 26'h0000C10, 32'h0);
        step(); check_pc("jump", 32'h3040, 10'h010, 1'b0, 1'b0);
        drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h3100);
        step(); check_pc("jr_3100", 32'h3100, 10'h040, 1'b0, 1'b0);

        // Stall suppresses both the update and the legality check
        drive(1'b1, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        step(); check_pc("stall1", 32'h3100, 10'h040, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h3101);
        step(); check_pc("stall2_bad", 32'h3100, 10'h040, 1'b0, 1'b0);
        drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h3101);
        step(); check_pc("misaligned", 32'h3100, 10'h040, 1'b1, 1'b1);

        // Reset out of HALT
        Reset = 1'b1;
        step(); check_pc("reset_halt", 32'h3000, 10'h000, 1'b0, 1'b0);
        Reset = 1'b0;

        // Last legal word, then sequential fetch past the top
        drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h3FFC);
        step(); check_pc("jr_top", 32'h3FFC, 10'h3FF, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        step(); check_pc("seq_past_top", 32'h3FFC, 10'h3FF, 1'b1, 1'b1);
        Reset = 1'b1;
        step(); check_pc("reset_top", 32'h3000, 10'h000, 1'b0, 1'b0);
        Reset = 1'b0;

        // Reset asserted mid-stall
        drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        step(); check_pc("seq_pre_stall", 32'h3004, 10'h001, 1'b0, 1'b0);
        drive(1'b1, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        Reset = 1'b1;
        step(); check_pc("reset_stall", 32'h3000, 10'h000, 1'b0, 1'b0);
        Reset = 1'b0;

        // Below-base target halts; HALT ignores every input afterwards
        drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h2FFC);
        step(); check_pc("below_base", 32'h3000, 10'h000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(i[0], 2'(i), 1'b1, 16'h0004, 26'h0000C20, 32'h3010 + 32'(4 * i));
            step();
            check_pc($sformatf("halt_frozen%0d", i), 32'h3000, 10'h000, 1'b1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
